// File: rtl/resp_checker_if.sv
// Response-checker bus: run control, response beat handshake and result outputs.
// Latency: n/a (signal bundle only).
// Backpressure: resp_ready (driven by the checker) qualifies resp_valid.
//
// Ports (as seen from the slave/checker side):
//   in : start, num_pat, ack, resp_valid, resp_in, exp_in
//   out: resp_ready, busy, done, pat_cnt, fail_cnt, first_fail, detected, signature
interface resp_checker_if #(
  parameter int CNT_W = 16,
  parameter int SIG_W = 16
);
  logic             start;
  logic [CNT_W-1:0] num_pat;
  logic             ack;
  logic             resp_valid;
  logic             resp_in;
  logic             exp_in;
  logic             resp_ready;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] pat_cnt;
  logic [CNT_W-1:0] fail_cnt;
  logic [CNT_W-1:0] first_fail;
  logic             detected;
  logic [SIG_W-1:0] signature;

  // Stimulus / test-controller side.
  modport master (
    output start, num_pat, ack, resp_valid, resp_in, exp_in,
    input  resp_ready, busy, done, pat_cnt, fail_cnt, first_fail, detected, signature
  );

  // Checker side.
  modport slave (
    input  start, num_pat, ack, resp_valid, resp_in, exp_in,
    output resp_ready, busy, done, pat_cnt, fail_cnt, first_fail, detected, signature
  );
endinterface

// File: rtl/resp_checker.sv
// Purpose: compares a stream of 1-bit DUT responses against golden values,
//          counting patterns/mismatches and (optionally) compacting them in a MISR.
// Latency: every result updates on the edge that accepts the beat; all outputs registered.
// Backpressure: resp_ready is high only in RUN; beats offered outside RUN are dropped.
//
// Ports: clk, rst (synchronous, active-high); bus (resp_checker_if.slave) carries
//   start/num_pat/ack control, the resp_valid/resp_ready beat handshake with
//   resp_in/exp_in, and the result outputs busy, done, pat_cnt, fail_cnt,
//   first_fail, detected, signature.
// Option: define RESP_CHECKER_MISR_EN to build the MISR; otherwise signature is 0.
module resp_checker #(
  parameter int                CNT_W = 16,
  parameter int                SIG_W = 16,
  parameter logic [SIG_W-1:0]  POLY  = SIG_W'(16'h8016)
) (
  input  logic                 clk,
  input  logic                 rst,
  resp_checker_if.slave        bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONES = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q,      state_d;
  logic [CNT_W-1:0] num_q,        num_d;
  logic [CNT_W-1:0] pat_cnt_q,    pat_cnt_d;
  logic [CNT_W-1:0] fail_cnt_q,   fail_cnt_d;
  logic [CNT_W-1:0] first_fail_q, first_fail_d;
  logic             detected_q,   detected_d;
  logic             resp_ready_q, resp_ready_d;
  logic             busy_q,       busy_d;
  logic             done_q,       done_d;

  logic             accept;
  logic             mismatch;
  logic [CNT_W-1:0] pat_inc;

`ifdef RESP_CHECKER_MISR_EN
  logic [SIG_W-1:0] sig_q, sig_d;
  logic [SIG_W-1:0] sig_next;

  // Shift left, fold the dropped MSB back through the taps, inject resp_in at bit 0.
  always_comb begin
    sig_next = {sig_q[SIG_W-2:0], 1'b0}
             ^ (sig_q[SIG_W-1] ? POLY : '0)
             ^ {{(SIG_W-1){1'b0}}, bus.resp_in};
  end
`endif

  // resp_ready_q is only ever set while in RUN, so it alone qualifies a beat.
  assign accept   = resp_ready_q & bus.resp_valid;
  assign mismatch = bus.resp_in ^ bus.exp_in;
  assign pat_inc  = pat_cnt_q + CNT_ONE;

  always_comb begin
    state_d      = state_q;
    num_d        = num_q;
    pat_cnt_d    = pat_cnt_q;
    fail_cnt_d   = fail_cnt_q;
    first_fail_d = first_fail_q;
    resp_ready_d = resp_ready_q;
    busy_d       = busy_q;
    done_d       = done_q;
`ifdef RESP_CHECKER_MISR_EN
    sig_d        = sig_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          pat_cnt_d    = '0;
          fail_cnt_d   = '0;
          first_fail_d = CNT_ONES;
`ifdef RESP_CHECKER_MISR_EN
          sig_d        = '0;
`endif
          if (bus.num_pat == '0) begin
            // Empty run: nothing to accept, report immediately.
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d      = S_RUN;
            num_d        = bus.num_pat;
            resp_ready_d = 1'b1;
            busy_d       = 1'b1;
          end
        end
      end

      S_RUN: begin
        if (accept) begin
          pat_cnt_d = pat_inc;
          if (mismatch) begin
            if (fail_cnt_q != CNT_ONES) begin
              fail_cnt_d = fail_cnt_q + CNT_ONE;
            end
            // fail_cnt saturates rather than wrapping, so zero means "no mismatch yet".
            if (fail_cnt_q == '0) begin
              first_fail_d = pat_cnt_q;
            end
          end
`ifdef RESP_CHECKER_MISR_EN
          sig_d = sig_next;
`endif
          // The last beat drops ready on the same edge so later beats are refused.
          if (pat_inc == num_q) begin
            state_d      = S_DONE;
            resp_ready_d = 1'b0;
            busy_d       = 1'b0;
            done_d       = 1'b1;
          end
        end
      end

      S_DONE: begin
        // start is ignored here, including when it coincides with ack.
        if (bus.ack) begin
          state_d = S_IDLE;
          done_d  = 1'b0;
        end
      end

      default: begin
        state_d      = S_IDLE;
        resp_ready_d = 1'b0;
        busy_d       = 1'b0;
        done_d       = 1'b0;
      end
    endcase

    detected_d = (fail_cnt_d != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      num_q        <= '0;
      pat_cnt_q    <= '0;
      fail_cnt_q   <= '0;
      first_fail_q <= CNT_ONES;
      detected_q   <= 1'b0;
      resp_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      num_q        <= num_d;
      pat_cnt_q    <= pat_cnt_d;
      fail_cnt_q   <= fail_cnt_d;
      first_fail_q <= first_fail_d;
      detected_q   <= detected_d;
      resp_ready_q <= resp_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

`ifdef RESP_CHECKER_MISR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign bus.signature = sig_q;
`else
  // No compactor in this build; the masked POLY folds to a constant zero.
  localparam logic [SIG_W-1:0] SIG_TIE = POLY & '0;
  assign bus.signature = SIG_TIE;
`endif

  assign bus.resp_ready = resp_ready_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pat_cnt    = pat_cnt_q;
  assign bus.fail_cnt   = fail_cnt_q;
  assign bus.first_fail = first_fail_q;
  assign bus.detected   = detected_q;

endmodule

// File: tb/tb_resp_checker.sv
// Directed table-driven bench for resp_checker, plus a long MISR run.
// Latency: each vector is driven on the falling edge and checked 1 time unit after the rising edge.
// Backpressure: beats are offered regardless of resp_ready; the expected tables encode which are taken.
module tb_resp_checker;

  localparam logic [15:0] FF = 16'hFFFF;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  resp_checker_if #(.CNT_W(16), .SIG_W(16)) bus ();

  resp_checker #(.CNT_W(16), .SIG_W(16), .POLY(16'h8016)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    string       nm;
    logic        rst, start;
    logic [15:0] num;
    logic        vld, rin, ein, ack;
    logic        rdy, busy, done;
    logic [15:0] pat, fail, ff;
    logic        det;
    logic [15:0] sig;   // value with the MISR built in
  } vec_t;

  vec_t vt[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  function automatic vec_t mk(string nm, logic r, logic s, logic [15:0] n,
                              logic v, logic ri, logic ei, logic a,
                              logic erdy, logic ebusy, logic edone,
                              logic [15:0] ep, logic [15:0] ef, logic [15:0] eff,
                              logic edet, logic [15:0] esig);
    vec_t x;
    x.nm = nm; x.rst = r; x.start = s; x.num = n; x.vld = v; x.rin = ri; x.ein = ei; x.ack = a;
    x.rdy = erdy; x.busy = ebusy; x.done = edone; x.pat = ep; x.fail = ef; x.ff = eff;
    x.det = edet; x.sig = esig;
    return x;
  endfunction

  function automatic logic [15:0] sig_exp(logic [15:0] misr_val);
`ifdef RESP_CHECKER_MISR_EN
    return misr_val;
`else
    return (misr_val & 16'h0000);
`endif
  endfunction

  task automatic check_out(string nm, logic erdy, logic ebusy, logic edone,
                           logic [15:0] ep, logic [15:0] ef, logic [15:0] eff,
                           logic edet, logic [15:0] esig);
    n_vec++;
    if (bus.resp_ready !== erdy || bus.busy !== ebusy || bus.done !== edone ||
        bus.pat_cnt !== ep || bus.fail_cnt !== ef || bus.first_fail !== eff ||
        bus.detected !== edet || bus.signature !== esig) begin
      n_miss++;
      $display("FAIL %s: got rdy=%b busy=%b done=%b pat=%h fail=%h ff=%h det=%b sig=%h, want rdy=%b busy=%b done=%b pat=%h fail=%h ff=%h det=%b sig=%h",
               nm, bus.resp_ready, bus.busy, bus.done, bus.pat_cnt, bus.fail_cnt,
               bus.first_fail, bus.detected, bus.signature,
               erdy, ebusy, edone, ep, ef, eff, edet, esig);
    end
  endtask

  task automatic drive(logic r, logic s, logic [15:0] n, logic v, logic ri, logic ei, logic a);
    @(negedge clk);
    rst            = r;
    bus.start      = s;
    bus.num_pat    = n;
    bus.resp_valid = v;
    bus.resp_in    = ri;
    bus.exp_in     = ei;
    bus.ack        = a;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.start = 1'b0; bus.num_pat = '0; bus.resp_valid = 1'b0;
    bus.resp_in = 1'b0; bus.exp_in = 1'b0; bus.ack = 1'b0;

    //              name           rst st num  vld ri ei ack | rdy bsy dn pat fail ff  det sig
    // Reset, then four matching beats.
    vt.push_back(mk("reset",        1, 0, 0,   0, 0, 0, 0,    0, 0, 0, 0, 0, FF, 0, 16'h0000));
    vt.push_back(mk("s1_start",     0, 1, 4,   0, 0, 0, 0,    1, 1, 0, 0, 0, FF, 0, 16'h0000));
    vt.push_back(mk("s1_b0",        0, 0, 0,   1, 1, 1, 0,    1, 1, 0, 1, 0, FF, 0, 16'h0001));
    vt.push_back(mk("s1_b1",        0, 0, 0,   1, 0, 0, 0,    1, 1, 0, 2, 0, FF, 0, 16'h0002));
    vt.push_back(mk("s1_b2",        0, 0, 0,   1, 1, 1, 0,    1, 1, 0, 3, 0, FF, 0, 16'h0005));
    vt.push_back(mk("s1_b3_done",   0, 0, 0,   1, 1, 1, 0,    0, 0, 1, 4, 0, FF, 0, 16'h000B));
    vt.push_back(mk("s1_hold",      0, 0, 0,   1, 0, 1, 0,    0, 0, 1, 4, 0, FF, 0, 16'h000B));
    vt.push_back(mk("s1_ack",       0, 0, 0,   0, 0, 0, 1,    0, 0, 0, 4, 0, FF, 0, 16'h000B));
    vt.push_back(mk("idle_ack_nop", 0, 0, 0,   1, 1, 0, 1,    0, 0, 0, 4, 0, FF, 0, 16'h000B));
    // Five beats, mismatches on indices 2 and 4, with a bubble.
    vt.push_back(mk("s2_start",     0, 1, 5,   0, 0, 0, 0,    1, 1, 0, 0, 0, FF, 0, 16'h0000));
    vt.push_back(mk("s2_b0",        0, 0, 0,   1, 0, 0, 0,    1, 1, 0, 1, 0, FF, 0, 16'h0000));
    vt.push_back(mk("s2_bubble",    0, 0, 0,   0, 1, 0, 0,    1, 1, 0, 1, 0, FF, 0, 16'h0000));
    vt.push_back(mk("s2_b1",        0, 0, 0,   1, 0, 0, 0,    1, 1, 0, 2, 0, FF, 0, 16'h0000));
    vt.push_back(mk("s2_b2_mis",    0, 0, 0,   1, 1, 0, 0,    1, 1, 0, 3, 1, 2,  1, 16'h0001));
    vt.push_back(mk("s2_b3",        0, 0, 0,   1, 0, 0, 0,    1, 1, 0, 4, 1, 2,  1, 16'h0002));
    vt.push_back(mk("s2_b4_mis",    0, 0, 0,   1, 1, 0, 0,    0, 0, 1, 5, 2, 2,  1, 16'h0005));
    vt.push_back(mk("s2_ack_start", 0, 1, 7,   0, 0, 0, 1,    0, 0, 0, 5, 2, 2,  1, 16'h0005));
    vt.push_back(mk("s2_idle_hold", 0, 0, 0,   0, 0, 0, 0,    0, 0, 0, 5, 2, 2,  1, 16'h0005));
    // Three beats with valid held for six cycles; start in DONE ignored.
    vt.push_back(mk("s3_start",     0, 1, 3,   0, 0, 0, 0,    1, 1, 0, 0, 0, FF, 0, 16'h0000));
    vt.push_back(mk("s3_v0",        0, 0, 0,   1, 1, 1, 0,    1, 1, 0, 1, 0, FF, 0, 16'h0001));
    vt.push_back(mk("s3_v1",        0, 0, 0,   1, 1, 1, 0,    1, 1, 0, 2, 0, FF, 0, 16'h0003));
    vt.push_back(mk("s3_v2_done",   0, 0, 0,   1, 1, 1, 0,    0, 0, 1, 3, 0, FF, 0, 16'h0007));
    vt.push_back(mk("s3_v3_drop",   0, 0, 0,   1, 1, 0, 0,    0, 0, 1, 3, 0, FF, 0, 16'h0007));
    vt.push_back(mk("s3_v4_start",  0, 1, 2,   1, 1, 0, 0,    0, 0, 1, 3, 0, FF, 0, 16'h0007));
    vt.push_back(mk("s3_v5_drop",   0, 0, 0,   1, 1, 0, 0,    0, 0, 1, 3, 0, FF, 0, 16'h0007));
    vt.push_back(mk("s3_ack",       0, 0, 0,   0, 0, 0, 1,    0, 0, 0, 3, 0, FF, 0, 16'h0007));
    // Empty run.
    vt.push_back(mk("s4_num0",      0, 1, 0,   0, 0, 0, 0,    0, 0, 1, 0, 0, FF, 0, 16'h0000));
    vt.push_back(mk("s4_ack",       0, 0, 0,   0, 0, 0, 1,    0, 0, 0, 0, 0, FF, 0, 16'h0000));
    // Reset mid-run beats start/ack/valid in the same cycle, then a normal run.
    vt.push_back(mk("s5_start",     0, 1, 8,   0, 0, 0, 0,    1, 1, 0, 0, 0, FF, 0, 16'h0000));
    vt.push_back(mk("s5_b0_mis",    0, 0, 0,   1, 1, 0, 0,    1, 1, 0, 1, 1, 0,  1, 16'h0001));
    vt.push_back(mk("s5_b1",        0, 0, 0,   1, 1, 1, 0,    1, 1, 0, 2, 1, 0,  1, 16'h0003));
    vt.push_back(mk("s5_rst",       1, 1, 3,   1, 1, 0, 1,    0, 0, 0, 0, 0, FF, 0, 16'h0000));
    vt.push_back(mk("s5_idle",      0, 0, 0,   0, 0, 0, 0,    0, 0, 0, 0, 0, FF, 0, 16'h0000));
    vt.push_back(mk("s5_restart",   0, 1, 2,   0, 0, 0, 0,    1, 1, 0, 0, 0, FF, 0, 16'h0000));
    vt.push_back(mk("s5_r_b0",      0, 0, 0,   1, 0, 0, 0,    1, 1, 0, 1, 0, FF, 0, 16'h0000));
    vt.push_back(mk("s5_r_b1",      0, 0, 0,   1, 1, 1, 0,    0, 0, 1, 2, 0, FF, 0, 16'h0001));
    vt.push_back(mk("s5_ack",       0, 0, 0,   0, 0, 0, 1,    0, 0, 0, 2, 0, FF, 0, 16'h0001));
    // Signature example: resp_in 1,1,0 from zero gives 0x0006.
    vt.push_back(mk("s6_start",     0, 1, 3,   0, 0, 0, 0,    1, 1, 0, 0, 0, FF, 0, 16'h0000));
    vt.push_back(mk("s6_b0",        0, 0, 0,   1, 1, 1, 0,    1, 1, 0, 1, 0, FF, 0, 16'h0001));
    vt.push_back(mk("s6_b1",        0, 0, 0,   1, 1, 1, 0,    1, 1, 0, 2, 0, FF, 0, 16'h0003));
    vt.push_back(mk("s6_b2",        0, 0, 0,   1, 0, 0, 0,    0, 0, 1, 3, 0, FF, 0, 16'h0006));
    vt.push_back(mk("s6_ack",       0, 0, 0,   0, 0, 0, 1,    0, 0, 0, 3, 0, FF, 0, 16'h0006));

    foreach (vt[i]) begin
      drive(vt[i].rst, vt[i].start, vt[i].num, vt[i].vld, vt[i].rin, vt[i].ein, vt[i].ack);
      check_out(vt[i].nm, vt[i].rdy, vt[i].busy, vt[i].done, vt[i].pat, vt[i].fail,
                vt[i].ff, vt[i].det, sig_exp(vt[i].sig));
    end

    // Long run exercising MISR feedback: a single 1 then 17 zeros, valid every other cycle.
    // After 16 shifts the 1 reaches bit 15 (0x8000); next beat folds POLY -> 0x8016;
    // the next shifts to 0x002C and folds again -> 0x803A.
    begin
      bit got_done = 1'b0;
      bit first    = 1'b1;
      drive(0, 1, 18, 0, 0, 0, 0);
      check_out("misr_start", 1, 1, 0, 0, 0, FF, 0, 16'h0000);
      for (int cyc = 0; cyc < 200 && !got_done; cyc++) begin
        if (cyc % 2 == 0) begin
          drive(0, 0, 0, 1, first, first, 0);
          first = 1'b0;
        end else begin
          drive(0, 0, 0, 0, 1, 0, 0);
        end
        if (bus.done === 1'b1) got_done = 1'b1;
      end
      n_vec++;
      if (!got_done) begin
        n_miss++;
        $display("FAIL misr_timeout: got done=%b after 200 cycles, want done=1", bus.done);
      end
      check_out("misr_done", 0, 0, 1, 18, 0, FF, 0, sig_exp(16'h803A));
      drive(0, 0, 0, 0, 0, 0, 1);
      check_out("misr_ack", 0, 0, 0, 18, 0, FF, 0, sig_exp(16'h803A));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
